// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC launch sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: fine-code width, chain tap count, sequencer state enum,
// res_data field offsets and a small constant helper for sizing counters.
package tdc_pkg;

  localparam int FINE_W = 5;
  localparam int TAPS   = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_VALID,
    S_HOLD,
    S_SETTLE
  } state_t;

  // res_data layout, LSB first: fine, delay, idx, err (MSB).
  localparam int FINE_LSB = 0;
  localparam int DLY_LSB  = FINE_LSB + FINE_W;

  function automatic int idx_lsb(input int dly_w);
    return DLY_LSB + dly_w;
  endfunction

  function automatic int err_bit(input int cnt_w, input int dly_w);
    return idx_lsb(dly_w) + cnt_w;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_cycle_timer.sv
// Loadable down-counter with zero flag; stops at zero.
// Latency: load takes effect on the next clk edge; zero is decoded from the count register.
// Backpressure: none; counts every cycle unless reloaded.
// Ports: clk, rst (sync, active-high), load/load_val (reload), zero (count == 0).
module tdc_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tdc_launch_sequencer.sv
// Launch/sample sequencer for the carry-chain TDC fine stage; emits {err, idx, delay, fine} per measurement.
// Latency: sample strobe D cycles after launch rises; result valid 2 cycles after sample when fine_valid returns next cycle.
// Backpressure: result held stable with launch low until res_ready; burst resumes SETTLE_CYCLES after the handshake.
// Ports: start/abort/meas_count/delay_init/sweep (control), launch_o/sample_o (to fine stage),
// fine_count/fine_valid (from fine stage), res_data/res_valid/res_ready (result stream), busy/done/err_sticky (status).
module tdc_launch_sequencer
  import tdc_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int DLY_W         = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int TIMEOUT       = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [CNT_W-1:0]          meas_count,
  input  logic [DLY_W-1:0]          delay_init,
  input  logic                      sweep,
  output logic                      launch_o,
  output logic                      sample_o,
  input  logic [FINE_W-1:0]         fine_count,
  input  logic                      fine_valid,
  output logic [CNT_W+DLY_W+FINE_W:0] res_data,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      err_sticky
);

  // One timer serves sample delay, timeout and settle, so it must hold the largest of the three.
  localparam int TMR_W = max3(DLY_W, $clog2(TIMEOUT + 1), $clog2(SETTLE_CYCLES + 1));

  state_t           state;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [DLY_W-1:0] delay_q;
  logic             sweep_q;

  logic             start_ok;
  logic [DLY_W-1:0] dly_start;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_zero;

  assign start_ok  = start && (meas_count != '0) && !abort;
  // A zero delay would put the sample strobe on the launch cycle itself; clamp to one.
  assign dly_start = (delay_init == '0) ? DLY_W'(1) : delay_init;

  // Timer reloads happen on the same edge as the matching state transition.
  // Loading N-1 makes zero assert in the Nth cycle of the new state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(dly_start) - TMR_W'(1);
        end
      end
      S_LAUNCH: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIMEOUT - 1);
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(SETTLE_CYCLES - 1);
        end
      end
      S_SETTLE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(delay_q) - TMR_W'(1);
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  tdc_cycle_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      delay_q    <= '0;
      sweep_q    <= 1'b0;
      launch_o   <= 1'b0;
      sample_o   <= 1'b0;
      res_data   <= '0;
      res_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort drops everything in flight, including an unaccepted result.
        state     <= S_IDLE;
        launch_o  <= 1'b0;
        sample_o  <= 1'b0;
        res_valid <= 1'b0;
        res_data  <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_ok) begin
              cnt_q      <= meas_count;
              delay_q    <= dly_start;
              sweep_q    <= sweep;
              idx_q      <= '0;
              err_sticky <= 1'b0;
              launch_o   <= 1'b1;
              busy       <= 1'b1;
              state      <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            if (tmr_zero) begin
              sample_o <= 1'b1;
              state    <= S_WAIT_VALID;
            end
          end
          S_WAIT_VALID: begin
            sample_o <= 1'b0;
            if (fine_valid) begin
              res_data  <= {1'b0, idx_q, delay_q, fine_count};
              res_valid <= 1'b1;
              launch_o  <= 1'b0;
              state     <= S_HOLD;
            end else if (tmr_zero) begin
              res_data   <= {1'b1, idx_q, delay_q, {FINE_W{1'b0}}};
              res_valid  <= 1'b1;
              launch_o   <= 1'b0;
              err_sticky <= 1'b1;
              state      <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (res_ready) begin
              res_valid <= 1'b0;
              idx_q     <= idx_q + CNT_W'(1);
              if (sweep_q && (delay_q != '1)) begin
                delay_q <= delay_q + DLY_W'(1);
              end
              state <= S_SETTLE;
            end
          end
          S_SETTLE: begin
            if (tmr_zero) begin
              if (idx_q == cnt_q) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                launch_o <= 1'b1;
                state    <= S_LAUNCH;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_launch_sequencer.sv
module tb_tdc_launch_sequencer;

  localparam int CNT_W  = 8;
  localparam int DLY_W  = 4;
  localparam int SETTLE = 4;
  localparam int TMO    = 8;

  logic        clk = 1'b0;
  logic        rst, start, abort, sweep;
  logic [7:0]  meas_count;
  logic [3:0]  delay_init;
  logic        launch_o, sample_o;
  logic [4:0]  fine_count;
  logic        fine_valid;
  logic [17:0] res_data;
  logic        res_valid, res_ready, busy, done, err_sticky;

  tdc_launch_sequencer #(
    .CNT_W(CNT_W), .DLY_W(DLY_W), .SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .meas_count(meas_count), .delay_init(delay_init), .sweep(sweep),
    .launch_o(launch_o), .sample_o(sample_o),
    .fine_count(fine_count), .fine_valid(fine_valid),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .done(done), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Fine-stage stub: answers one cycle after each sample strobe.
  logic       stub_en = 1'b0;
  logic       prev_sample = 1'b0;
  logic [4:0] stub_codes [8];
  int         stub_ptr = 0;

  // Burst recording
  logic [17:0] res_q [16];
  int res_cyc [16];
  int samp_off [16];
  int samp_cyc [16];
  int lr_cyc [16];
  int nr, ns, nl, ndone, done_cyc, t0;
  logic done_busy, timed_out;

  function automatic logic [17:0] pack(input logic e, input logic [7:0] i,
                                       input logic [3:0] d, input logic [4:0] f);
    return {e, i, d, f};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    fine_valid = 1'b0;
    if (stub_en && prev_sample && stub_ptr < 8) begin
      fine_valid = 1'b1;
      fine_count = stub_codes[stub_ptr];
      stub_ptr++;
    end
    prev_sample = sample_o;
  endtask

  task automatic run_burst(input logic [7:0] cnt, input logic [3:0] dly,
                           input logic sw, input int poke);
    logic pl;
    nr = 0; ns = 0; nl = 0; ndone = 0; done_cyc = 0; t0 = 0;
    done_busy = 1'b1; timed_out = 1'b1;
    stub_ptr = 0; prev_sample = 1'b0;
    meas_count = cnt; delay_init = dly; sweep = sw; start = 1'b1;
    pl = launch_o;
    for (int i = 0; i < 600; i++) begin
      cycle();
      start = 1'b0;
      if (i == poke) begin
        start = 1'b1; meas_count = 8'd5; delay_init = 4'd9; sweep = 1'b1;
      end
      if (launch_o && !pl) begin
        t0 = cyc;
        if (nl < 16) lr_cyc[nl] = cyc;
        nl++;
      end
      pl = launch_o;
      if (sample_o && ns < 16) begin samp_off[ns] = cyc - t0; samp_cyc[ns] = cyc; ns++; end
      if (res_valid && res_ready && nr < 16) begin res_q[nr] = res_data; res_cyc[nr] = cyc; nr++; end
      if (done) begin ndone++; done_busy = busy; done_cyc = cyc; end
      if (!busy) begin timed_out = 1'b0; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; sweep = 1'b0;
    meas_count = '0; delay_init = '0; fine_count = '0; fine_valid = 1'b0; res_ready = 1'b0;
    repeat (3) cycle();
    checks++;
    if ({launch_o, sample_o, res_valid, res_data, busy, done, err_sticky} !== 24'd0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {launch_o, sample_o, res_valid, res_data, busy, done, err_sticky});
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || launch_o !== 1'b0) begin
      errors++; $display("FAIL reset_release busy=%b launch=%b exp 0 0", busy, launch_o);
    end
  endtask

  task automatic test_basic();
    stub_codes[0] = 5'd7; stub_codes[1] = 5'd8; stub_codes[2] = 5'd9;
    stub_en = 1'b1; res_ready = 1'b1;
    run_burst(8'd3, 4'd2, 1'b0, -1);
    checks++;
    if (timed_out !== 1'b0 || nr != 3) begin
      errors++; $display("FAIL basic_count results=%0d timed_out=%b exp 3 0", nr, timed_out);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (res_q[k] !== pack(1'b0, 8'(k), 4'd2, 5'(7 + k))) begin
        errors++; $display("FAIL basic_res%0d got %h exp %h", k, res_q[k], pack(1'b0, 8'(k), 4'd2, 5'(7 + k)));
      end
      checks++;
      if (samp_off[k] != 2) begin
        errors++; $display("FAIL basic_sample_off%0d got %0d exp 2", k, samp_off[k]);
      end
      checks++;
      if (res_cyc[k] - samp_cyc[k] != 2) begin
        errors++; $display("FAIL basic_res_latency%0d got %0d exp 2", k, res_cyc[k] - samp_cyc[k]);
      end
    end
    for (int k = 1; k < 3; k++) begin
      checks++;
      if (lr_cyc[k] - res_cyc[k-1] != SETTLE + 1) begin
        errors++; $display("FAIL basic_relaunch%0d got %0d exp %0d", k, lr_cyc[k] - res_cyc[k-1], SETTLE + 1);
      end
    end
    checks++;
    if (ndone != 1 || done_busy !== 1'b0) begin
      errors++; $display("FAIL basic_done pulses=%0d busy_at_done=%b exp 1 0", ndone, done_busy);
    end
    checks++;
    if (done_cyc - res_cyc[2] != SETTLE + 1) begin
      errors++; $display("FAIL basic_done_time got %0d exp %0d", done_cyc - res_cyc[2], SETTLE + 1);
    end
  endtask

  task automatic test_sweep();
    int ed [4];
    ed[0] = 14; ed[1] = 15; ed[2] = 15; ed[3] = 15;
    for (int k = 0; k < 4; k++) stub_codes[k] = 5'(k + 1);
    stub_en = 1'b1; res_ready = 1'b1;
    run_burst(8'd4, 4'd14, 1'b1, -1);
    checks++;
    if (nr != 4 || ndone != 1) begin
      errors++; $display("FAIL sweep_count results=%0d done=%0d exp 4 1", nr, ndone);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (res_q[k] !== pack(1'b0, 8'(k), 4'(ed[k]), 5'(k + 1))) begin
        errors++; $display("FAIL sweep_res%0d got %h exp %h", k, res_q[k], pack(1'b0, 8'(k), 4'(ed[k]), 5'(k + 1)));
      end
      checks++;
      if (samp_off[k] != ed[k]) begin
        errors++; $display("FAIL sweep_sample_off%0d got %0d exp %0d", k, samp_off[k], ed[k]);
      end
    end
  endtask

  task automatic test_timeout();
    stub_en = 1'b0; res_ready = 1'b1;
    run_burst(8'd1, 4'd0, 1'b0, -1);
    checks++;
    if (nr != 1 || res_q[0] !== pack(1'b1, 8'd0, 4'd1, 5'd0)) begin
      errors++; $display("FAIL timeout_res count=%0d got %h exp %h", nr, res_q[0], pack(1'b1, 8'd0, 4'd1, 5'd0));
    end
    checks++;
    if (samp_off[0] != 1) begin
      errors++; $display("FAIL timeout_zero_delay got %0d exp 1", samp_off[0]);
    end
    checks++;
    if (res_cyc[0] - samp_cyc[0] != TMO) begin
      errors++; $display("FAIL timeout_latency got %0d exp %0d", res_cyc[0] - samp_cyc[0], TMO);
    end
    checks++;
    if (err_sticky !== 1'b1 || ndone != 1) begin
      errors++; $display("FAIL timeout_sticky sticky=%b done=%0d exp 1 1", err_sticky, ndone);
    end
    repeat (5) cycle();
    meas_count = 8'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    checks++;
    if (err_sticky !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL timeout_sticky_hold sticky=%b busy=%b exp 1 0", err_sticky, busy);
    end
    stub_codes[0] = 5'd12; stub_en = 1'b1; stub_ptr = 0; prev_sample = 1'b0;
    meas_count = 8'd1; delay_init = 4'd1; sweep = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    checks++;
    if (err_sticky !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky_clear sticky=%b busy=%b exp 0 1", err_sticky, busy);
    end
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (!busy) break;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL timeout_followup_end busy=%b exp 0", busy);
    end
  endtask

  task automatic test_backpressure();
    logic [17:0] held, res2;
    logic pl;
    int bad, c, lrc, nd;
    stub_codes[0] = 5'd3; stub_codes[1] = 5'd4;
    stub_en = 1'b1; stub_ptr = 0; prev_sample = 1'b0; res_ready = 1'b0;
    meas_count = 8'd2; delay_init = 4'd1; sweep = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) break;
      cycle();
    end
    held = res_data;
    checks++;
    if (res_valid !== 1'b1 || held !== pack(1'b0, 8'd0, 4'd1, 5'd3)) begin
      errors++; $display("FAIL bp_first valid=%b got %h exp %h", res_valid, held, pack(1'b0, 8'd0, 4'd1, 5'd3));
    end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (res_valid !== 1'b1 || res_data !== held || launch_o !== 1'b0 || sample_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_hold bad_cycles=%0d exp 0", bad);
    end
    res_ready = 1'b1;
    c = cyc; lrc = -1; nd = 0; res2 = '0; pl = launch_o;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (launch_o && !pl && lrc < 0) lrc = cyc;
      pl = launch_o;
      if (res_valid && res_ready) res2 = res_data;
      if (done) nd++;
      if (!busy) break;
    end
    checks++;
    if (lrc - c != SETTLE + 1) begin
      errors++; $display("FAIL bp_resume got %0d exp %0d", lrc - c, SETTLE + 1);
    end
    checks++;
    if (res2 !== pack(1'b0, 8'd1, 4'd1, 5'd4) || nd != 1) begin
      errors++; $display("FAIL bp_second got %h done=%0d exp %h 1", res2, nd, pack(1'b0, 8'd1, 4'd1, 5'd4));
    end
  endtask

  task automatic test_abort();
    int act;
    logic seen;
    stub_en = 1'b0; res_ready = 1'b1; prev_sample = 1'b0;
    meas_count = 8'd3; delay_init = 4'd3; sweep = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (sample_o) begin seen = 1'b1; break; end
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++; $display("FAIL abort_sample_seen got %b exp 1", seen);
    end
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    checks++;
    if ({launch_o, sample_o, res_valid, busy, done, err_sticky, res_data} !== 24'd0) begin
      errors++; $display("FAIL abort_outputs got %h exp 0", {launch_o, sample_o, res_valid, busy, done, err_sticky, res_data});
    end
    act = 0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (done || res_valid || busy) act++;
    end
    checks++;
    if (act != 0) begin
      errors++; $display("FAIL abort_quiet active_cycles=%0d exp 0", act);
    end
    stub_codes[0] = 5'd6; stub_en = 1'b1;
    run_burst(8'd1, 4'd1, 1'b0, -1);
    checks++;
    if (nr != 1 || res_q[0] !== pack(1'b0, 8'd0, 4'd1, 5'd6) || ndone != 1) begin
      errors++; $display("FAIL abort_restart count=%0d got %h done=%0d exp 1 %h 1", nr, res_q[0], ndone, pack(1'b0, 8'd0, 4'd1, 5'd6));
    end
    meas_count = 8'd2; start = 1'b1; abort = 1'b1;
    cycle();
    start = 1'b0; abort = 1'b0;
    cycle();
    checks++;
    if (busy !== 1'b0 || launch_o !== 1'b0) begin
      errors++; $display("FAIL abort_with_start busy=%b launch=%b exp 0 0", busy, launch_o);
    end
  endtask

  task automatic test_reset_hold();
    stub_codes[0] = 5'd2; stub_en = 1'b1; stub_ptr = 0; prev_sample = 1'b0; res_ready = 1'b0;
    meas_count = 8'd2; delay_init = 4'd1; sweep = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (res_valid) break;
      cycle();
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL rsthold_reach got %b exp 1", res_valid);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if ({res_valid, busy, launch_o, sample_o, done} !== 5'd0) begin
      errors++; $display("FAIL rsthold_outputs got %b exp 00000", {res_valid, busy, launch_o, sample_o, done});
    end
    rst = 1'b0; res_ready = 1'b1;
    repeat (3) cycle();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errors++; $display("FAIL rsthold_idle busy=%b valid=%b exp 0 0", busy, res_valid);
    end
  endtask

  task automatic test_ignored();
    stub_en = 1'b1; res_ready = 1'b1;
    run_burst(8'd0, 4'd3, 1'b0, -1);
    checks++;
    if (busy !== 1'b0 || nl != 0) begin
      errors++; $display("FAIL ign_zero_count busy=%b launches=%0d exp 0 0", busy, nl);
    end
    stub_codes[0] = 5'd10; stub_codes[1] = 5'd11;
    run_burst(8'd2, 4'd2, 1'b0, 3);
    checks++;
    if (nr != 2 || ndone != 1) begin
      errors++; $display("FAIL ign_busy_count results=%0d done=%0d exp 2 1", nr, ndone);
    end
    checks++;
    if (res_q[0] !== pack(1'b0, 8'd0, 4'd2, 5'd10) || res_q[1] !== pack(1'b0, 8'd1, 4'd2, 5'd11)) begin
      errors++; $display("FAIL ign_busy_res got %h %h exp %h %h", res_q[0], res_q[1],
                         pack(1'b0, 8'd0, 4'd2, 5'd10), pack(1'b0, 8'd1, 4'd2, 5'd11));
    end
    stub_en = 1'b0;
    cycle();
    fine_valid = 1'b1; fine_count = 5'd21;
    cycle();
    cycle();
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ign_spurious_valid valid=%b busy=%b exp 0 0", res_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_timeout();
    test_backpressure();
    test_abort();
    test_reset_hold();
    test_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
